// File: rtl/merger_leaf_refill_scheduler.sv
// Purpose: shares one memory read-request port among all leaf FIFOs of the merge tree for one sort pass.
// Latency: request fields are registered one cycle after arbitration; at most one request every 2 cycles.
// Backpressure: request held stable while !i_req_ready; a leaf is requested only when its credits cover the burst.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_start, i_base_addr, i_run_len   pass start pulse and pass parameters (latched in IDLE)
//   i_leaf_read                       per-leaf dequeue pulses from the tree (credit return)
//   i_out_write                       tree root write pulse (pass progress)
//   o_req_valid/i_req_ready           read request handshake
//   o_req_addr, o_req_len, o_req_leaf request fields
//   o_busy, o_done                    pass in progress, one-cycle completion pulse
module merger_leaf_refill_scheduler #(
    parameter int NUM_LEAVES = 64,
    parameter int LOG_LEAVES = 6,
    parameter int FIFO_DEPTH = 16,
    parameter int BURST      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 20
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [ADDR_WIDTH-1:0]     i_base_addr,
    input  logic [LEN_WIDTH-1:0]      i_run_len,
    input  logic [NUM_LEAVES-1:0]     i_leaf_read,
    input  logic                      i_out_write,
    output logic                      o_req_valid,
    input  logic                      i_req_ready,
    output logic [ADDR_WIDTH-1:0]     o_req_addr,
    output logic [$clog2(BURST):0]    o_req_len,
    output logic [LOG_LEAVES-1:0]     o_req_leaf,
    output logic                      o_busy,
    output logic                      o_done
);
    localparam int CW  = $clog2(FIFO_DEPTH + 1) + 1; // headroom so a stray extra return cannot wrap
    localparam int RLW = $clog2(BURST) + 1;
    localparam int OCW = LEN_WIDTH + LOG_LEAVES + 1;
    localparam int PW  = LEN_WIDTH + LOG_LEAVES;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_ARB, S_ISSUE, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]         credit [NUM_LEAVES];
    logic [LEN_WIDTH-1:0]  issued [NUM_LEAVES];
    logic [OCW-1:0]        out_cnt;
    logic [LOG_LEAVES-1:0] rr_ptr;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [LEN_WIDTH-1:0]  run_len;

    logic [LEN_WIDTH-1:0]  rem      [NUM_LEAVES];
    logic [RLW-1:0]        want_len [NUM_LEAVES];
    logic [NUM_LEAVES-1:0] elig;
    logic                  all_done;
    logic                  sel_found;
    logic [LOG_LEAVES-1:0] sel_idx;
    logic [LOG_LEAVES-1:0] cand;
    logic [PW-1:0]         run_off;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [OCW-1:0]        pass_total;
    logic                  hs;

    assign hs          = (state == S_ISSUE) && i_req_ready;
    assign o_req_valid = (state == S_ISSUE);
    assign o_busy      = (state != S_IDLE);
    assign o_done      = (state == S_DONE);
    assign pass_total  = OCW'(NUM_LEAVES) * OCW'(run_len);

    // A leaf may only be requested when its FIFO has room for the whole burst.
    always_comb begin
        rem      = '{default: '0};
        want_len = '{default: '0};
        elig     = '0;
        all_done = 1'b1;
        for (int k = 0; k < NUM_LEAVES; k++) begin
            rem[k]      = run_len - issued[k];
            want_len[k] = (rem[k] > LEN_WIDTH'(BURST)) ? RLW'(BURST) : RLW'(rem[k]);
            elig[k]     = (rem[k] != '0) && (credit[k] >= CW'(want_len[k]));
            if (rem[k] != '0) begin
                all_done = 1'b0;
            end
        end
    end

    // Round-robin: first eligible leaf at or after rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            cand = LOG_LEAVES'((int'(rr_ptr) + i) % NUM_LEAVES);
            if (!sel_found && elig[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Runs are stored back to back; address arithmetic wraps at ADDR_WIDTH.
    assign run_off  = PW'(sel_idx) * PW'(run_len);
    assign sel_addr = base_addr + ADDR_WIDTH'(run_off) + ADDR_WIDTH'(issued[sel_idx]);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_INIT;
            S_INIT:  state_nxt = (run_len == '0) ? S_DONE : S_ARB;
            S_ARB: begin
                if (sel_found)     state_nxt = S_ISSUE;
                else if (all_done) state_nxt = S_DRAIN;
            end
            S_ISSUE: if (i_req_ready) state_nxt = S_ARB;
            S_DRAIN: if (out_cnt == pass_total) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_LEAVES; k++) begin
                credit[k] <= '0;
                issued[k] <= '0;
            end
            out_cnt    <= '0;
            rr_ptr     <= '0;
            base_addr  <= '0;
            run_len    <= '0;
            o_req_addr <= '0;
            o_req_len  <= '0;
            o_req_leaf <= '0;
        end else begin
            if (state == S_IDLE && i_start) begin
                base_addr <= i_base_addr;
                run_len   <= i_run_len;
            end
            if (state == S_INIT) begin
                for (int k = 0; k < NUM_LEAVES; k++) begin
                    credit[k] <= CW'(FIFO_DEPTH);
                    issued[k] <= '0;
                end
                out_cnt <= '0;
                rr_ptr  <= '0;
            end else if (state != S_IDLE) begin
                // Return and grant on the same leaf in one cycle both apply.
                for (int k = 0; k < NUM_LEAVES; k++) begin
                    credit[k] <= credit[k] + CW'(i_leaf_read[k])
                               - ((hs && o_req_leaf == LOG_LEAVES'(k)) ? CW'(o_req_len) : CW'(0));
                end
                if (hs) begin
                    issued[o_req_leaf] <= issued[o_req_leaf] + LEN_WIDTH'(o_req_len);
                    rr_ptr <= (o_req_leaf == LOG_LEAVES'(NUM_LEAVES - 1)) ? '0
                              : o_req_leaf + LOG_LEAVES'(1);
                end
                if (i_out_write) begin
                    out_cnt <= out_cnt + OCW'(1);
                end
            end
            if (state == S_ARB && sel_found) begin
                o_req_leaf <= sel_idx;
                o_req_len  <= want_len[sel_idx];
                o_req_addr <= sel_addr;
            end
        end
    end
endmodule

// File: tb/tb_merger_leaf_refill_scheduler.sv
// Bench for merger_leaf_refill_scheduler: table of full passes plus hand-written corner sequences.
// A leaf/root model returns credits and root writes; a request scoreboard holds expected bursts.
// Expected bursts are derived from the pass parameters, not from the DUT.
module tb_merger_leaf_refill_scheduler;
    localparam int NL    = 64;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic [31:0]   i_base_addr = '0;
    logic [19:0]   i_run_len = '0;
    logic [NL-1:0] i_leaf_read = '0;
    logic          i_out_write = 1'b0;
    logic          o_req_valid;
    logic          i_req_ready = 1'b0;
    logic [31:0]   o_req_addr;
    logic [2:0]    o_req_len;
    logic [5:0]    o_req_leaf;
    logic          o_busy;
    logic          o_done;

    merger_leaf_refill_scheduler dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_run_len(i_run_len), .i_leaf_read(i_leaf_read), .i_out_write(i_out_write),
        .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_addr(o_req_addr),
        .o_req_len(o_req_len), .o_req_leaf(o_req_leaf), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  leaf;
        logic [31:0] addr;
        logic [2:0]  len;
    } req_t;

    typedef struct {
        logic [31:0] base;
        logic [19:0] run_len;
        bit          poke;      // pulse i_start mid-pass
        int          exp_reqs;
        int          max_lat;   // 0: no latency bound
    } vec_t;

    req_t          sb[$];
    int            checks = 0;
    int            failures = 0;
    int            occ [NL];
    int            pend [NL];
    int            iss [NL];
    int            out_pend, writes, req_count, done_cnt, writes_at_done, cur_len;
    bit            auto_deq, auto_out;
    logic [NL-1:0] man_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_model();
        sb.delete();
        for (int k = 0; k < NL; k++) begin
            occ[k] = 0; pend[k] = 0; iss[k] = 0;
        end
        out_pend = 0; writes = 0; req_count = 0; done_cnt = 0;
        writes_at_done = -1; man_rd = '0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_start = 1'b0;
        tick();
        clear_model();
        i_rst = 1'b0;
    endtask

    // Expected bursts: all leaves in round-robin order, one round per BURST-sized chunk.
    task automatic push_pass(input logic [31:0] base, input int len, input int max_rounds);
        for (int r = 0; r * 4 < len && r < max_rounds; r++) begin
            for (int k = 0; k < NL; k++) begin
                req_t e;
                e.leaf = 6'(k);
                e.addr = base + 32'(k) * 32'(len) + 32'(r * 4);
                e.len  = 3'((len - r * 4) > 4 ? 4 : (len - r * 4));
                sb.push_back(e);
            end
        end
    endtask

    task automatic start_pass(input logic [31:0] base, input logic [19:0] len);
        i_base_addr = base; i_run_len = len; i_start = 1'b1;
        tick();
        i_start = 1'b0; i_base_addr = 32'hDEAD_BEEF; i_run_len = 20'd3;
    endtask

    task automatic wait_reqs(input string name, input int n, input int budget);
        int c = 0;
        while (req_count < n && c < budget) begin
            tick(); c++;
        end
        chk(name, req_count, n);
    endtask

    task automatic pulse_leaf(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            man_rd[k] = 1'b1;
            tick();
        end
    endtask

    // Leaf FIFO / tree root model, evaluated mid-cycle.
    initial begin
        logic [NL-1:0] rd;
        logic          wr;
        req_t          e;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                i_leaf_read = '0; i_out_write = 1'b0;
            end else begin
                if (o_done) begin
                    done_cnt++; writes_at_done = writes;
                end
                rd = man_rd; man_rd = '0;
                for (int k = 0; k < NL; k++) begin
                    if (auto_deq && pend[k] > 0) begin
                        rd[k] = 1'b1; pend[k]--;
                    end
                    if (rd[k]) begin
                        occ[k]--; out_pend++;
                    end
                end
                wr = auto_out && out_pend > 0;
                if (wr) begin
                    out_pend--; writes++;
                end
                if (o_req_valid && i_req_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_req leaf=%0d addr=%0h len=%0d required=none",
                                 o_req_leaf, o_req_addr, o_req_len);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("req%0d_leaf", req_count), o_req_leaf, e.leaf);
                        chk($sformatf("req%0d_addr", req_count), o_req_addr, e.addr);
                        chk($sformatf("req%0d_len", req_count), o_req_len, e.len);
                    end
                    iss[o_req_leaf] += int'(o_req_len);
                    occ[o_req_leaf] += int'(o_req_len);
                    if (auto_deq) pend[o_req_leaf] += int'(o_req_len);
                    checks++;
                    if (occ[o_req_leaf] > DEPTH || iss[o_req_leaf] > cur_len) begin
                        failures++;
                        $display("FAIL leaf_bound leaf=%0d occupancy=%0d issued=%0d required occ<=%0d issued<=%0d",
                                 o_req_leaf, occ[o_req_leaf], iss[o_req_leaf], DEPTH, cur_len);
                    end
                    req_count++;
                end
                i_leaf_read = rd; i_out_write = wr;
            end
        end
    end

    task automatic run_pass(input vec_t v);
        int  lat = 0;
        bit  poked = 1'b0;
        clear_model();
        cur_len = int'(v.run_len); auto_deq = 1'b1; auto_out = 1'b1; i_req_ready = 1'b1;
        push_pass(v.base, int'(v.run_len), 1 << 20);
        start_pass(v.base, v.run_len);
        chk("busy_after_start", o_busy, 1);
        while (done_cnt == 0 && lat < 6000) begin
            i_start = 1'b0;
            if (v.poke && !poked && req_count >= 10) begin
                i_start = 1'b1; poked = 1'b1;
            end
            tick(); lat++;
        end
        i_start = 1'b0;
        chk("done_seen", done_cnt > 0, 1);
        if (v.max_lat > 0) chk("done_latency_ok", lat <= v.max_lat, 1);
        repeat (5) tick();
        chk("done_pulses", done_cnt, 1);
        chk("busy_after_done", o_busy, 0);
        chk("sb_left", sb.size(), 0);
        chk("req_count", req_count, v.exp_reqs);
        chk("writes_at_done", writes_at_done, NL * int'(v.run_len));
    endtask

    initial begin
        vec_t vt [5];
        int   c, vcnt;
        vt[0] = '{32'h0000_1000, 20'd8, 1'b0, 128, 0};
        vt[1] = '{32'h0000_2000, 20'd6, 1'b0, 128, 0};
        vt[2] = '{32'hFFFF_FFF0, 20'd5, 1'b1, 128, 0};
        vt[3] = '{32'h0000_3000, 20'd0, 1'b0, 0, 2};
        vt[4] = '{32'h0000_0000, 20'd1, 1'b0, 64, 0};
        auto_deq = 1'b1; auto_out = 1'b1; cur_len = 0;
        clear_model();

        do_reset();
        chk("rst_valid", o_req_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_addr", o_req_addr, 0);
        chk("rst_len", o_req_len, 0);
        chk("rst_leaf", o_req_leaf, 0);

        // Reset while a request is pending in ISSUE.
        i_req_ready = 1'b0; cur_len = 8;
        start_pass(32'h1000, 20'd8);
        c = 0;
        while (!o_req_valid && c < 20) begin
            tick(); c++;
        end
        chk("midrst_pending", o_req_valid, 1);
        chk("midrst_leaf", o_req_leaf, 0);
        chk("midrst_addr", o_req_addr, 32'h1000);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("midrst_valid", o_req_valid, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_addr0", o_req_addr, 0);
        repeat (20) tick();
        chk("midrst_no_done", done_cnt, 0);

        // Full passes; the first restarts from leaf 0 after the abandoned pass.
        for (int i = 0; i < 5; i++) run_pass(vt[i]);

        // Credit stall with backpressure on leaf 0's fourth burst.
        clear_model();
        auto_deq = 1'b0; auto_out = 1'b0; cur_len = 40; i_req_ready = 1'b1;
        push_pass(32'h4000, 40, 4);
        start_pass(32'h4000, 20'd40);
        wait_reqs("stall_first_192", 192, 1000);
        i_req_ready = 1'b0;
        c = 0;
        while (!o_req_valid && c < 10) begin
            tick(); c++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", o_req_valid, 1);
            chk("bp_leaf", o_req_leaf, 0);
            chk("bp_addr", o_req_addr, 32'h4000 + 12);
            chk("bp_len", o_req_len, 4);
            tick();
        end
        i_req_ready = 1'b1; man_rd[0] = 1'b1;   // return on the granted leaf in the handshake cycle
        tick();
        wait_reqs("stall_all_256", 256, 500);
        vcnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (o_req_valid) vcnt++;
            tick();
        end
        chk("stall_quiet", vcnt, 0);
        chk("stall_sb_empty", sb.size(), 0);
        pulse_leaf(5, 1);
        repeat (10) tick();
        chk("leaf5_one_credit_no_req", req_count, 256);
        sb.push_back('{6'd5, 32'h4000 + 5 * 40 + 16, 3'd4});
        pulse_leaf(5, 3);
        wait_reqs("leaf5_refill", 257, 20);
        // Leaf 0 holds 1 credit after the net +1-4 in its handshake cycle.
        sb.push_back('{6'd0, 32'h4000 + 16, 3'd4});
        pulse_leaf(0, 3);
        wait_reqs("leaf0_net_credit", 258, 20);
        chk("stall_sb_done", sb.size(), 0);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
